dot3_requester: RTL and testbench

Initiator side of the serial dot-product protocol. Accepts a job of two 3-element FP32 vectors on a valid/ready port and streams it to one `dot_product_3x1`-protocol responder over `ready`/`data_valid`/`data`. It then collects the scalar result from `calc_done`/`result`, releases the responder with `read_done`, and presents the result with its tag on a valid/ready output. It sits between the render pipeline's job scheduler and each dot-product engine.

---
 rtl/dot3_requester.sv | 135 +++++++++++++
 tb/tb_dot3_requester.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot3_requester.sv
// Initiator for the serial dot-product protocol: streams a two-vector job to one responder and returns its tagged result.
// Optional watchdog is enabled with `define DOT3_REQ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module dot3_requester #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [95:0]      job_a,
    input  logic [95:0]      job_b,
    input  logic [TAG_W-1:0] job_tag,
    input  logic             dp_ready,
    output logic             dp_data_valid,
    output logic [31:0]      dp_data,
    input  logic             dp_calc_done,
    input  logic [31:0]      dp_result,
    output logic             dp_read_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_RDY  = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_CALC = 3'd3;
    localparam logic [2:0] S_REL       = 3'd4;
    localparam logic [2:0] S_RESULT    = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [2:0]       beat_cnt;
    logic [95:0]      a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      res_data_q;
    logic             res_err_q;
    logic             wd_hit;

`ifdef DOT3_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = ((state == S_WAIT_RDY) || (state == S_WAIT_CALC)) &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change so each wait state gets a full budget.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT_RDY) || (state == S_WAIT_CALC)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (job_valid)               state_nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (dp_ready)                state_nxt = S_SEND;
                         else if (wd_hit)             state_nxt = S_RESULT;
            S_SEND:      if (beat_cnt == 3'd6)        state_nxt = S_WAIT_CALC;
            S_WAIT_CALC: if (dp_calc_done)            state_nxt = S_REL;
                         else if (wd_hit)             state_nxt = S_RESULT;
            S_REL:       if (dp_ready)                state_nxt = S_RESULT;
            S_RESULT:    if (res_ready)               state_nxt = S_IDLE;
            default:                                  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= (state == S_SEND) ? beat_cnt + 3'd1 : 3'd0;
            if (state == S_IDLE && job_valid) begin
                a_q   <= job_a;
                b_q   <= job_b;
                tag_q <= job_tag;
            end
            if (state == S_WAIT_CALC && dp_calc_done) begin
                res_data_q <= dp_result;
                res_err_q  <= 1'b0;
            end else if (wd_hit && state_nxt == S_RESULT) begin
                res_data_q <= '1;
                res_err_q  <= 1'b1;
            end
        end
    end

    // Beat 0 is the wake-up word; it repeats a0 and is discarded by the responder.
    always_comb begin
        dp_data = '0;
        if (state == S_SEND) begin
            case (beat_cnt)
                3'd0, 3'd1: dp_data = a_q[31:0];
                3'd2:       dp_data = a_q[63:32];
                3'd3:       dp_data = a_q[95:64];
                3'd4:       dp_data = b_q[31:0];
                3'd5:       dp_data = b_q[63:32];
                3'd6:       dp_data = b_q[95:64];
                default:    dp_data = '0;
            endcase
        end
    end

    assign job_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign dp_data_valid = (state == S_SEND);
    assign dp_read_done  = (state == S_REL);
    assign res_valid     = (state == S_RESULT);
    assign res_data      = res_data_q;
    assign res_tag       = tag_q;
`ifdef DOT3_REQ_TIMEOUT_EN
    assign res_err       = res_err_q;
`else
    assign res_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dot3_requester.sv
// Directed bench for dot3_requester with a behavioural dot_product_3x1 responder model.
module tb_dot3_requester;

    logic        iClk = 1'b0;
    logic        iRstn = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [95:0] job_a = '0;
    logic [95:0] job_b = '0;
    logic [3:0]  job_tag = '0;
    logic        dp_ready;
    logic        dp_data_valid;
    logic [31:0] dp_data;
    logic        dp_calc_done;
    logic [31:0] dp_result;
    logic        dp_read_done;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;

    dot3_requester #(.TAG_W(4), .TIMEOUT_CYCLES(50)) dut (
        .iClk(iClk), .iRstn(iRstn),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .job_tag(job_tag),
        .dp_ready(dp_ready), .dp_data_valid(dp_data_valid), .dp_data(dp_data),
        .dp_calc_done(dp_calc_done), .dp_result(dp_result), .dp_read_done(dp_read_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy)
    );

    always #5 iClk = ~iClk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Responder model: idle -> load (6 payload beats) -> compute -> done (2 cycles) -> wait release.
    logic        hold_ready = 1'b0;
    logic        rsp_hang = 1'b0;
    logic [31:0] rsp_value = '0;
    logic        rdy_q;
    logic [2:0]  rs;
    logic [2:0]  ld_cnt;
    logic [3:0]  c_cnt;
    logic        d_cnt;
    assign dp_ready = rdy_q & ~hold_ready;

    always @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            rs <= 3'd0; rdy_q <= 1'b1; ld_cnt <= '0; c_cnt <= '0; d_cnt <= 1'b0;
            dp_calc_done <= 1'b0; dp_result <= '0;
        end else begin
            case (rs)
                3'd0: if (dp_data_valid && dp_ready) begin rs <= 3'd1; rdy_q <= 1'b0; ld_cnt <= '0; end
                3'd1: if (dp_data_valid) begin
                          ld_cnt <= ld_cnt + 3'd1;
                          if (ld_cnt == 3'd5) begin rs <= 3'd2; c_cnt <= '0; end
                      end
                3'd2: if (!rsp_hang && c_cnt == 4'd9) begin
                          rs <= 3'd3; d_cnt <= 1'b0; dp_calc_done <= 1'b1; dp_result <= rsp_value;
                      end else if (!rsp_hang) c_cnt <= c_cnt + 4'd1;
                3'd3: if (!d_cnt) d_cnt <= 1'b1;
                      else begin
                          dp_calc_done <= 1'b0; dp_result <= '0;
                          if (dp_read_done) begin rs <= 3'd0; rdy_q <= 1'b1; end
                          else rs <= 3'd4;
                      end
                3'd4: if (dp_read_done) begin rs <= 3'd0; rdy_q <= 1'b1; end
                default: rs <= 3'd0;
            endcase
        end
    end

    // Monitor: cycle stamps, beat capture and contiguity of each SEND burst.
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    logic [31:0] beats[$];
    int run = 0;
    int fb_cyc = 0, cd_cyc = 0, rd_cyc = 0, rv_cyc = 0;
    logic cd_prev = 0, rd_prev = 0, rv_prev = 0, rd_seen = 0;

    always @(negedge iClk) begin
        if (!iRstn) begin
            run = 0;
        end else begin
            if (dp_data_valid) begin
                if (run == 0) fb_cyc = cyc;
                run++;
                beats.push_back(dp_data);
            end else if (run != 0) begin
                chk("beat_run_len", run, 7);
                run = 0;
            end
            if (dp_calc_done && !cd_prev) cd_cyc = cyc;
            if (dp_read_done && !rd_prev) rd_cyc = cyc;
            if (res_valid && !rv_prev) rv_cyc = cyc;
            if (dp_read_done) rd_seen = 1'b1;
        end
        cd_prev = dp_calc_done;
        rd_prev = dp_read_done;
        rv_prev = res_valid;
    end

    int acc_cyc = 0;

    task automatic offer(input logic [95:0] a, input logic [95:0] b, input logic [3:0] tag,
                         input logic [31:0] rv);
        int n;
        beats.delete();
        rsp_value = rv;
        @(negedge iClk);
        job_a = a; job_b = b; job_tag = tag; job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 200) begin @(negedge iClk); n++; end
        chk("job_accept", job_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge iClk);
        #1 job_valid = 1'b0;
    endtask

    task automatic collect(input logic [31:0] exp_d, input logic [3:0] exp_t, input logic exp_e);
        int n;
        n = 0;
        while (!res_valid && n < 500) begin @(negedge iClk); n++; end
        chk("res_valid", res_valid, 1'b1);
        chk("res_data", res_data, exp_d);
        chk("res_tag", res_tag, exp_t);
        chk("res_err", res_err, exp_e);
        if (res_ready) begin
            @(negedge iClk);
            chk("res_valid_drop", res_valid, 1'b0);
            chk("job_ready_back", job_ready, 1'b1);
        end
    endtask

    task automatic check_beats(input logic [31:0] e [7]);
        chk("beat_count", beats.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < beats.size()) chk($sformatf("beat%0d", i), beats[i], e[i]);
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_job_ready"}, job_ready, 1'b1);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_dvalid"}, dp_data_valid, 1'b0);
        chk({pfx, "_data"}, dp_data, 32'h0);
        chk({pfx, "_read_done"}, dp_read_done, 1'b0);
        chk({pfx, "_res_valid"}, res_valid, 1'b0);
        chk({pfx, "_res_data"}, res_data, 32'h0);
        chk({pfx, "_res_tag"}, res_tag, 4'h0);
        chk({pfx, "_res_err"}, res_err, 1'b0);
    endtask

    logic [31:0] e1 [7] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] e4 [7] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h40800000,
                           32'h40400000, 32'h40000000, 32'h3E800000};
    logic [31:0] bk [4] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    logic [31:0] rk [4] = '{32'h00000000, 32'h40400000, 32'h40C00000, 32'h41100000};

    initial begin
        int nv;
        repeat (3) @(negedge iClk);
        #2 iRstn = 1'b1;
        @(negedge iClk);
        check_idle_outputs("reset");

        // Single job: a={3,2,1}, b={6,5,4}, dot = 32.0
        offer({32'h40400000, 32'h40000000, 32'h3F800000},
              {32'h40C00000, 32'h40A00000, 32'h40800000}, 4'd5, 32'h42000000);
        collect(32'h42000000, 4'd5, 1'b0);
        check_beats(e1);
        chk("first_beat_lat", fb_cyc - acc_cyc, 2);
        chk("read_done_lat", rd_cyc - cd_cyc, 1);
        chk("res_valid_lat", rv_cyc - cd_cyc, 3);

        // Responder held busy for 20 cycles after accept
        hold_ready = 1'b1;
        offer({3{32'h3F800000}}, {3{32'h40000000}}, 4'd9, 32'h40C00000);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            if (dp_data_valid) nv++;
        end
        chk("hold_no_beats", nv, 0);
        chk("hold_busy", busy, 1'b1);
        hold_ready = 1'b0;
        @(negedge iClk);
        chk("hold_first_beat", dp_data_valid, 1'b1);
        chk("hold_first_data", dp_data, 32'h3F800000);
        collect(32'h40C00000, 4'd9, 1'b0);

        // Result back-pressure with a second job waiting
        res_ready = 1'b0;
        offer({3{32'h3F800000}}, {3{32'h3F800000}}, 4'd3, 32'h40400000);
        collect(32'h40400000, 4'd3, 1'b0);
        job_a = {3{32'h40000000}}; job_b = {3{32'h3F800000}}; job_tag = 4'd7;
        job_valid = 1'b1;
        rsp_value = 32'h40C00000;
        for (int i = 0; i < 15; i++) begin
            @(negedge iClk);
            chk("bp_res_valid", res_valid, 1'b1);
            chk("bp_res_data", res_data, 32'h40400000);
            chk("bp_res_tag", res_tag, 4'd3);
            chk("bp_job_ready", job_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(negedge iClk);
        chk("bp_released", res_valid, 1'b0);
        chk("bp_job_ready_after", job_ready, 1'b1);
        beats.delete();
        @(posedge iClk);
        #1 job_valid = 1'b0;
        collect(32'h40C00000, 4'd7, 1'b0);

        // Reset pulsed during SEND at beat 3
        offer({32'h40800000, 32'h3F000000, 32'h40000000},
              {32'h3E800000, 32'h40000000, 32'h40400000}, 4'd1, 32'h41000000);
        nv = 0;
        while (!dp_data_valid && nv < 100) begin @(negedge iClk); nv++; end
        chk("rst_send_seen", dp_data_valid, 1'b1);
        repeat (3) @(negedge iClk);
        #2 iRstn = 1'b0;
        @(negedge iClk);
        chk("rst_dvalid_low", dp_data_valid, 1'b0);
        #2 iRstn = 1'b1;
        @(negedge iClk);
        check_idle_outputs("post_rst");
        offer({32'h40800000, 32'h3F000000, 32'h40000000},
              {32'h3E800000, 32'h40000000, 32'h40400000}, 4'd10, 32'h41000000);
        collect(32'h41000000, 4'd10, 1'b0);
        check_beats(e4);

        // Four jobs in a row, tags 0..3
        for (int k = 0; k < 4; k++) begin
            offer({3{32'h3F800000}}, {3{bk[k]}}, 4'(k), rk[k]);
            collect(rk[k], 4'(k), 1'b0);
            chk($sformatf("job%0d_beats", k), beats.size(), 7);
        end

`ifdef DOT3_REQ_TIMEOUT_EN
        // Responder never finishes: watchdog fires 50 cycles into WAIT_CALC
        rsp_hang = 1'b1;
        rd_seen = 1'b0;
        offer({3{32'h3F800000}}, {3{32'h3F800000}}, 4'd6, 32'h12345678);
        nv = 0;
        while (!dp_data_valid && nv < 100) begin @(negedge iClk); nv++; end
        while (dp_data_valid && nv < 100) begin @(negedge iClk); nv++; end
        nv = 0;
        while (!res_valid && nv < 200) begin @(negedge iClk); nv++; end
        chk("wd_latency", nv, 50);
        chk("wd_no_read_done", rd_seen, 1'b0);
        collect(32'hFFFFFFFF, 4'd6, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
